gpio_input: RTL and testbench
=============================

# gpio_input

Input-side GPIO peripheral for the processor, the counterpart of the 7-segment output port. It samples the board's slide switches and active-low push-buttons, synchronises and debounces them, and records button presses as sticky event flags. The processor reads either the switch levels or the event flags through a registered, enable-strobed read port. Reading the event flags clears them.

## Interface
Parameters:
- DATA_W, 21: read-data width, equal to the processor data-bus width.
- DEB_CYCLES, 50000: consecutive stable cycles needed to accept a new input level (1 ms at 50 MHz). Must be at least 2.

Ports:
- CLK  in  1  system clock; all state updates on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- SW  in  10  raw slide switches; asynchronous to CLK, bouncy.
- KEY  in  4  raw push-buttons, active-low (0 = pressed); asynchronous, bouncy.
- ena  in  1  read strobe, sampled on a rising CLK edge.
- sel  in  1  read select: 0 = switch levels, 1 = key event flags.
- DIN  out  DATA_W  read data, registered.
- valid  out  1  high for exactly the cycle after an accepted read.
- irq  out  1  OR of all pending key event flags.

## Operation
- **Synchroniser**
  - Each SW and KEY bit passes through a 2-flop synchroniser.
  - Reset values: SW flops to 0, KEY flops to 1 (released).
- **Debounce** (one counter per bit, 14 bits total; counter width = clog2(DEB_CYCLES))
  - If the synchronised bit equals the stable bit, the counter clears.
  - If they differ, the counter increments.
  - When the counter reaches DEB_CYCLES-1 while the bits still differ, the stable bit takes the new value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles never changes the stable bit.
  - Reset values: sw_stable = 0, key_stable = 4'hF, all counters 0.
- **Press detect**
  - new_press[i] = key_stable[i] & ~key_stable_next[i], i.e. a stable 1→0 transition.
  - new_press sets pending[i]. Release (0→1) has no effect.
- **Read** (on a rising edge with ena = 1)
  - sel = 0: DIN ← zero-extended sw_stable (bits 9:0, upper bits 0).
  - sel = 1: DIN ← zero-extended pending as it was before this edge (bits 3:0).
  - valid ← 1 in both cases.
- **Clear-on-read** (ena = 1 and sel = 1)
  - pending ← new_press for that edge.
  - Bits pressed in the same cycle remain set for the next read; a press is never lost.
- **No read** (ena = 0)
  - DIN holds its value; valid ← 0.
  - pending ← pending | new_press.
- **irq** is combinational from the pending register only; it has no path from raw inputs.
- **Reset mid-operation**: all state returns to its reset values immediately, including in-progress debounce counts and pending flags.

## Timing
- Reset values: DIN = 0, valid = 0, irq = 0.
- Input-to-stable latency: a clean level change appears in the stable bit 2 + DEB_CYCLES rising edges after it is first sampled.
- Press-to-flag latency: pending and irq rise on the same edge that key_stable falls.
- Read latency: 1 cycle. DIN and valid update on the edge that samples ena.
- Back-to-back reads: ena held high returns a new value every cycle and valid stays high.
  - A second consecutive sel = 1 read returns only presses that occurred since the previous read edge.
- Simultaneous events:
  - Clear and a new press on the same edge: the press wins, and its pending bit stays set.
  - A read of sel = 0 while a switch stable bit updates on the same edge: DIN gets the pre-edge value.

## Test plan
All scenarios use DEB_CYCLES = 4.
- **Reset**: assert RESET mid-simulation, asynchronously to CLK → DIN = 0, valid = 0 and irq = 0 immediately; a read with sel = 1 after release returns 0.
- **Switch read**: set SW = 10'h2A5 and hold for 10 cycles, then pulse ena with sel = 0 → DIN = 21'h0002A5 and valid high for exactly 1 cycle.
- **Debounce reject/accept**:
  - Toggle SW[0] at 1-0-1-0 with 3-cycle pulses → sw_stable[0] stays 0.
  - Hold SW[0] = 1 → sw_stable[0] = 1 exactly 6 edges after the first sampled 1.
- **Key event and clear-on-read**:
  - Press KEY[2] (drive 0) for 8 cycles, then release → irq = 1.
  - Read with sel = 1 → DIN = 21'h000004, and irq = 0 the next cycle.
  - A second read returns 0.
- **Press coincides with clear**: time a KEY[1] stable falling edge to land on the read edge with sel = 1 → that read returns the old flags, pending[1] = 1 afterwards, irq stays 1, and the next read returns 21'h000002.
- **Hold with no enable**: with ena low for 20 cycles while SW changes → DIN is unchanged and valid stays 0.

Source files
------------

// File: rtl/gpio_input.sv
// gpio_input: input-side GPIO peripheral.
// It synchronises and debounces the slide switches and active-low push-buttons.
// Button presses are held as sticky event flags, which are cleared when read.
// The processor reads either the switch levels or the event flags through a
// registered read port that updates only when the read strobe is high.
module gpio_input #(
    parameter int DATA_W     = 21,
    parameter int DEB_CYCLES = 50000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [9:0]        SW,
    input  logic [3:0]        KEY,
    input  logic              ena,
    input  logic              sel,
    output logic [DATA_W-1:0] DIN,
    output logic              valid,
    output logic              irq
);

    // Switches occupy bits 9:0 and keys occupy bits 13:10 of the combined vectors.
    localparam int NBITS = 14;
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Keys idle high (released) and switches idle low.
    localparam logic [NBITS-1:0] IDLE_LEVEL = {4'hF, 10'h000};

    logic [NBITS-1:0] r_sync1;
    logic [NBITS-1:0] r_sync2;
    logic [NBITS-1:0] r_stable;
    logic [CNT_W-1:0] r_cnt [NBITS];
    logic [3:0]       r_pending;

    logic [NBITS-1:0] w_stableNext;
    logic [CNT_W-1:0] w_cntNext [NBITS];
    logic [3:0]       w_newPress;
    logic [3:0]       w_pendingNext;
    logic [DATA_W-1:0] w_readData;

    // Two-flop synchroniser for all raw inputs, which are asynchronous to CLK.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
        end else begin
            r_sync1 <= {KEY, SW};
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: a bit accepts a new level only after the level has differed for DEB_CYCLES compares in a row.
    always_comb begin
        w_stableNext = r_stable;
        for (int i = 0; i < NBITS; i++) begin
            w_cntNext[i] = '0;
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_stableNext[i] = r_sync2[i];
                end else begin
                    w_cntNext[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Debounce state: the stable levels and their run-length counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_stable <= IDLE_LEVEL;
            for (int i = 0; i < NBITS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_stable <= w_stableNext;
            for (int i = 0; i < NBITS; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
        end
    end

    // A press is a stable high-to-low key transition.
    // A flag-read clears the old flags, but a press on the same edge is never lost.
    always_comb begin
        w_newPress = r_stable[13:10] & ~w_stableNext[13:10];
        if (ena && sel) begin
            w_pendingNext = w_newPress;
        end else begin
            w_pendingNext = r_pending | w_newPress;
        end
    end

    // The read mux returns pre-edge values, zero-extended to the bus width.
    always_comb begin
        w_readData = '0;
        if (sel) begin
            w_readData[3:0] = r_pending;
        end else begin
            w_readData[9:0] = r_stable[9:0];
        end
    end

    // Event flags and the registered read port.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_pending <= '0;
            DIN       <= '0;
            valid     <= 1'b0;
        end else begin
            r_pending <= w_pendingNext;
            valid     <= ena;
            if (ena) begin
                DIN <= w_readData;
            end
        end
    end

    // The interrupt comes only from the registered flags, never from raw inputs.
    always_comb begin
        irq = |r_pending;
    end

endmodule

// File: tb/tb_gpio_input.sv
// tb_gpio_input: directed, self-checking bench for gpio_input with DEB_CYCLES = 4.
module tb_gpio_input;

    localparam int DW = 21;

    logic          CLK;
    logic          RESET;
    logic [9:0]    SW;
    logic [3:0]    KEY;
    logic          ena;
    logic          sel;
    logic [DW-1:0] DIN;
    logic          valid;
    logic          irq;

    int checks;
    int errors;

    typedef struct {
        logic [9:0]    sw;
        logic [3:0]    key;
        logic          ena;
        logic          sel;
        int            cycles;
        logic [DW-1:0] expDin;
        logic          expValid;
        logic          expIrq;
    } vec_t;

    vec_t vecs [13];

    gpio_input #(
        .DATA_W     (DW),
        .DEB_CYCLES (4)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .SW    (SW),
        .KEY   (KEY),
        .ena   (ena),
        .sel   (sel),
        .DIN   (DIN),
        .valid (valid),
        .irq   (irq)
    );

    // Free-running 10-time-unit clock.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Advance to 1 time unit past the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive all data inputs with blocking assignments.
    task automatic applyStimulus(input logic [9:0] sw, input logic [3:0] key,
                                 input logic e, input logic s);
        SW  = sw;
        KEY = key;
        ena = e;
        sel = s;
    endtask

    // Compare every output against the expected values.
    task automatic checkOutput(input string name, input logic [DW-1:0] expDin,
                               input logic expValid, input logic expIrq);
        checks++;
        if (DIN !== expDin || valid !== expValid || irq !== expIrq) begin
            errors++;
            $display("[TB] FAIL %s: got DIN=%h valid=%b irq=%b, want DIN=%h valid=%b irq=%b",
                     name, DIN, valid, irq, expDin, expValid, expIrq);
        end
    endtask

    // Main test sequence.
    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b1;
        applyStimulus(10'h000, 4'hF, 1'b0, 1'b0);

        vecs[0]  = '{10'h000, 4'hF, 1'b0, 1'b0,  2, 21'h000000, 1'b0, 1'b0};
        vecs[1]  = '{10'h2A5, 4'hF, 1'b0, 1'b0, 10, 21'h000000, 1'b0, 1'b0};
        vecs[2]  = '{10'h2A5, 4'hF, 1'b1, 1'b0,  1, 21'h0002A5, 1'b1, 1'b0};
        vecs[3]  = '{10'h2A5, 4'hF, 1'b0, 1'b0,  1, 21'h0002A5, 1'b0, 1'b0};
        vecs[4]  = '{10'h2A5, 4'hB, 1'b0, 1'b0,  8, 21'h0002A5, 1'b0, 1'b1};
        vecs[5]  = '{10'h2A5, 4'hF, 1'b0, 1'b0,  8, 21'h0002A5, 1'b0, 1'b1};
        vecs[6]  = '{10'h2A5, 4'hF, 1'b1, 1'b1,  1, 21'h000004, 1'b1, 1'b0};
        vecs[7]  = '{10'h2A5, 4'hF, 1'b1, 1'b1,  1, 21'h000000, 1'b1, 1'b0};
        vecs[8]  = '{10'h2A5, 4'hF, 1'b0, 1'b0,  1, 21'h000000, 1'b0, 1'b0};
        vecs[9]  = '{10'h155, 4'hF, 1'b0, 1'b0, 10, 21'h000000, 1'b0, 1'b0};
        vecs[10] = '{10'h3FF, 4'hF, 1'b0, 1'b1, 10, 21'h000000, 1'b0, 1'b0};
        vecs[11] = '{10'h3FF, 4'hF, 1'b1, 1'b0,  1, 21'h0003FF, 1'b1, 1'b0};
        vecs[12] = '{10'h3FF, 4'hF, 1'b0, 1'b0,  3, 21'h0003FF, 1'b0, 1'b0};

        repeat (3) tick();
        checkOutput("reset_state", 21'h0, 1'b0, 1'b0);
        RESET = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].sw, vecs[i].key, vecs[i].ena, vecs[i].sel);
            repeat (vecs[i].cycles) tick();
            checkOutput($sformatf("vec%0d", i), vecs[i].expDin, vecs[i].expValid, vecs[i].expIrq);
        end

        // Short pulses on SW[0] must never reach the stable level; the switches are read every cycle.
        $display("[TB] debounce reject");
        applyStimulus(10'h000, 4'hF, 1'b1, 1'b0);
        repeat (10) tick();
        for (int p = 0; p < 4; p++) begin
            applyStimulus((p % 2 == 0) ? 10'h001 : 10'h000, 4'hF, 1'b1, 1'b0);
            for (int c = 0; c < 3; c++) begin
                tick();
                checkOutput($sformatf("reject_p%0d_c%0d", p, c), 21'h0, 1'b1, 1'b0);
            end
        end
        applyStimulus(10'h000, 4'hF, 1'b1, 1'b0);
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput($sformatf("reject_tail%0d", c), 21'h0, 1'b1, 1'b0);
        end

        // A held level reaches the stable bit on edge 6.
        // DIN shows the pre-edge level, so the new value first appears after edge 7.
        $display("[TB] debounce accept");
        applyStimulus(10'h001, 4'hF, 1'b1, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            checkOutput($sformatf("accept_edge%0d", k), (k >= 7) ? 21'h1 : 21'h0, 1'b1, 1'b0);
        end

        // A KEY[1] press lands on a flag-read edge while the KEY[3] flag is already pending.
        $display("[TB] press coincides with clear");
        applyStimulus(10'h001, 4'h7, 1'b0, 1'b0);
        repeat (8) tick();
        applyStimulus(10'h001, 4'hF, 1'b0, 1'b0);
        repeat (8) tick();
        checkOutput("key3_pending", 21'h1, 1'b0, 1'b1);
        applyStimulus(10'h001, 4'hD, 1'b0, 1'b0);
        repeat (5) tick();
        checkOutput("before_coincide", 21'h1, 1'b0, 1'b1);
        applyStimulus(10'h001, 4'hD, 1'b1, 1'b1);
        tick();
        checkOutput("coincide_read", 21'h000008, 1'b1, 1'b1);
        tick();
        checkOutput("after_coincide_read", 21'h000002, 1'b1, 1'b0);
        applyStimulus(10'h001, 4'hF, 1'b0, 1'b0);
        repeat (8) tick();
        checkOutput("idle_after_coincide", 21'h000002, 1'b0, 1'b0);

        // Assert reset asynchronously, between clock edges, while the outputs are non-zero.
        $display("[TB] async reset");
        applyStimulus(10'h001, 4'hE, 1'b0, 1'b0);
        repeat (8) tick();
        applyStimulus(10'h0F0, 4'hE, 1'b1, 1'b0);
        repeat (10) tick();
        checkOutput("pre_reset", 21'h0000F0, 1'b1, 1'b1);
        #3;
        RESET = 1'b1;
        #1;
        checkOutput("async_reset", 21'h0, 1'b0, 1'b0);
        applyStimulus(10'h0F0, 4'hF, 1'b0, 1'b0);
        repeat (3) tick();
        RESET = 1'b0;
        applyStimulus(10'h0F0, 4'hF, 1'b1, 1'b1);
        tick();
        checkOutput("read_after_reset", 21'h0, 1'b1, 1'b0);
        applyStimulus(10'h0F0, 4'hF, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
